// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// op encodings, FSM states and op-decoding helpers.
package mul_div_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    // Ops 000..011 are the iterative ones; bit 0 clear marks the signed flavour.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op[2:1] == 2'b01);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op[2] == 1'b0) && (op[0] == 1'b0);
    endfunction

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negation, used both to take operand
// magnitudes and to restore the sign of product, quotient and remainder.
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO
// registers; fixed WIDTH+1 cycle latency with a start/busy/done handshake.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e          state;
    logic               is_div;
    logic               div0;
    logic               neg_q;
    logic               neg_r;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mag_a_r;
    logic [WIDTH-1:0]   mag_b_r;
    logic [WIDTH-1:0]   a_orig;
    logic [2*WIDTH-1:0] acc;

    logic               neg_a_in;
    logic               neg_b_in;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    assign neg_a_in = is_signed_op(op) & a[WIDTH-1];
    assign neg_b_in = is_signed_op(op) & b[WIDTH-1];

    md_sign_fix #(.WIDTH(WIDTH)) u_mag_a (.value(a), .neg(neg_a_in), .result(mag_a));
    md_sign_fix #(.WIDTH(WIDTH)) u_mag_b (.value(b), .neg(neg_b_in), .result(mag_b));

    // Multiply step: acc holds {partial sum, remaining multiplier bits}.
    logic [WIDTH-1:0]   add_val;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign add_val  = acc[0] ? mag_a_r : '0;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, add_val};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide step: acc holds {remainder, dividend bits shifting into quotient}.
    logic [WIDTH:0]     rem_shift;
    logic               fits;
    logic [WIDTH-1:0]   rem_diff;
    logic [2*WIDTH-1:0] div_next;

    assign rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign fits      = (rem_shift >= {1'b0, mag_b_r});
    assign rem_diff  = rem_shift[WIDTH-1:0] - mag_b_r;
    assign div_next  = {(fits ? rem_diff : rem_shift[WIDTH-1:0]), acc[WIDTH-2:0], fits};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    md_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.value(acc), .neg(neg_q), .result(prod_fix));
    md_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.value(acc[WIDTH-1:0]), .neg(neg_q), .result(quo_fix));
    md_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.value(acc[2*WIDTH-1:WIDTH]), .neg(neg_r), .result(rem_fix));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            is_div  <= 1'b0;
            div0    <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            cnt     <= '0;
            mag_a_r <= '0;
            mag_b_r <= '0;
            a_orig  <= '0;
            acc     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if (is_arith_op(op)) begin
                            is_div  <= is_div_op(op);
                            div0    <= is_div_op(op) && (b == '0);
                            neg_q   <= neg_a_in ^ neg_b_in;
                            neg_r   <= neg_a_in;
                            mag_a_r <= mag_a;
                            mag_b_r <= mag_b;
                            a_orig  <= a;
                            acc     <= is_div_op(op) ? {{WIDTH{1'b0}}, mag_a}
                                                     : {{WIDTH{1'b0}}, mag_b};
                            cnt     <= '0;
                            busy    <= 1'b1;
                            state   <= ST_RUN;
                        end else if (op == MD_MTHI) begin
                            hi <= a;
                        end else if (op == MD_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    // abort wins over writeback so a flushed op leaves HI/LO untouched
                    if (!abort) begin
                        if (is_div && div0) begin
                            lo <= '1;
                            hi <= a_orig;
                        end else if (is_div) begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                        done <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised and directed bench for mul_div_unit against a plain-arithmetic
// reference model of MULT/MULTU/DIV/DIVU and the HI/LO move ops.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {hi, lo} from integer arithmetic on the architectural operands.
    function automatic logic [63:0] refModel(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            MD_MULT: begin
                q = sx * sy;
                return q;
            end
            MD_MULTU: begin
                p = 64'(x) * 64'(y);
                return p;
            end
            MD_DIV: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where done is observed.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                 input bit noise, input string tag);
        int k;
        int busy_cnt;
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(negedge clk);
        start    = 1'b0;
        k        = 0;
        busy_cnt = 0;
        while (!done && k < 100) begin
            if (busy) busy_cnt++;
            if (noise && k == 5) begin
                start = 1'b1; op = MD_MTHI; a = 32'hDEAD_BEEF; b = 32'h0;
            end
            if (noise && k == 6) begin
                op = MD_MULT; a = 32'h1; b = 32'h1;
            end
            if (noise && k == 7) start = 1'b0;
            @(negedge clk);
            k++;
        end
        checkOutput({tag, ".latency"}, 64'(k), 64'd33);
        checkOutput({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd33);
        checkOutput({tag, ".hi"}, 64'(hi), 64'(exp_hi));
        checkOutput({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    endtask

    task automatic applyRandom(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv, input string tag);
        logic [63:0] exp;
        exp = refModel(o, av, bv);
        applyStimulus(o, av, bv, exp[63:32], exp[31:0], 1'b0, tag);
    endtask

    initial begin
        int done_seen;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1; start = 1'b0; op = 3'b0; a = '0; b = '0; abort = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset.hi", 64'(hi), 64'd0);
        checkOutput("reset.lo", 64'(lo), 64'd0);
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
        @(negedge clk);
        checkOutput("multu_max.done_pulse", 64'(done), 64'd0);

        applyStimulus(MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg");
        applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_b2b");
        applyStimulus(MD_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b0, "divu_zero");
        applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, "div_min");

        // Register moves complete at the accepting edge with no handshake.
        start = 1'b1; op = MD_MTHI; a = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        checkOutput("mthi.hi", 64'(hi), 64'h1234_5678);
        checkOutput("mthi.busy", 64'(busy), 64'd0);
        checkOutput("mthi.done", 64'(done), 64'd0);
        start = 1'b1; op = MD_MTLO; a = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("mtlo.lo", 64'(lo), 64'h9ABC_DEF0);
        checkOutput("mtlo.hi", 64'(hi), 64'h1234_5678);
        checkOutput("mtlo.busy", 64'(busy), 64'd0);

        start = 1'b1; abort = 1'b1; op = MD_MTHI; a = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checkOutput("abort_idle.hi", 64'(hi), 64'h1234_5678);
        checkOutput("abort_idle.busy", 64'(busy), 64'd0);

        start = 1'b1; op = MD_MULTU; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_run.busy", 64'(busy), 64'd0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checkOutput("abort_run.no_done", 64'(done_seen), 64'd0);
        checkOutput("abort_run.hi", 64'(hi), 64'h1234_5678);
        checkOutput("abort_run.lo", 64'(lo), 64'h9ABC_DEF0);
        applyStimulus(MD_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, "multu_after_abort");

        applyStimulus(MD_MULTU, 32'h0001_0001, 32'h0001_0001, 32'h0000_0001, 32'h0002_0001, 1'b1, "multu_noise");

        start = 1'b1; op = MD_DIV; a = 32'hFFFF_FF9C; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst.busy", 64'(busy), 64'd0);
        checkOutput("async_rst.done", 64'(done), 64'd0);
        checkOutput("async_rst.hi", 64'(hi), 64'd0);
        checkOutput("async_rst.lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(MD_DIVU, 32'd17, 32'd5, 32'd2, 32'd3, 1'b0, "divu_17_5");

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            applyRandom(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Multi-cycle integer multiply/divide unit for the MIPS150 execute stage. It is the sequential, parametrised successor to the single-cycle ALU and owns the architectural HI/LO registers. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO. It uses an iterative shift-add multiplier and a restoring divider with a start/busy/done handshake. The pipeline stalls on busy and reads hi/lo for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits.
CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived; do not override).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
a  input  WIDTH  rs operand (multiplicand / dividend / MT source).
b  input  WIDTH  rt operand (multiplier / divisor).
abort  input  1  synchronous cancel (pipeline flush).
busy  output  1  operation in progress; the pipeline must stall MFHI/MFLO and new mul/div.
done  output  1  one-cycle pulse; hi/lo hold the new result in this cycle.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, any state): state=IDLE; hi=0, lo=0, busy=0, done=0; counter and working registers cleared.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE, start=1:
  - MTHI: hi<=a at that edge. No busy, no done.
  - MTLO: lo<=a at that edge. No busy, no done.
  - 11x: ignored.
  - Mul/div op:
    - Latch |a| and |b|. The sign flag applies only to signed ops; unsigned ops use the raw values.
    - Record neg_q = sign(a)^sign(b) and neg_r = sign(a).
    - Record div0 = (b==0) for div ops.
    - counter=0; busy<=1; go to RUN.
- start while busy=1: ignored; no queueing.
- RUN, one iteration per cycle for exactly WIDTH cycles, then go to FIX.
  - Multiply: 2*WIDTH product register, initialised to {0, |b|}.
    - If product lsb=1, add |a| into the upper half with a WIDTH+1-bit carry.
    - Then shift right by 1.
  - Divide (restoring): remainder shifts left, taking in the next quotient-register msb.
    - Trial subtract |b|.
    - If non-negative, keep the difference and shift in quotient bit 1; else shift in 0.
- FIX, single cycle:
  - Multiply: if signed and neg_q, negate the full 2*WIDTH product. Then hi<=upper, lo<=lower.
  - Divide, signed: negate the quotient if neg_q and the remainder if neg_r. Then lo<=quotient, hi<=remainder.
  - div0 overrides: lo<={WIDTH{1}}, hi<=a (original operand), for both DIV and DIVU.
  - busy<=0; done<=1 for one cycle; state IDLE.
- Latency: start sampled at edge E0; busy=1 after E0; hi/lo update and done rises at edge E(WIDTH+1). This is 33 cycles for WIDTH=32, regardless of operand values (no early termination).
- Back-to-back: a new start is accepted in the done cycle (busy=0).
- DIV MIN / -1: lo=MIN, hi=0. This falls out of the magnitude arithmetic; no special case and no exception.
- abort=1 in RUN or FIX: return to IDLE next edge; busy<=0; hi/lo unchanged; no done.
  - abort has priority over FIX writeback.
  - abort together with start in IDLE: start is ignored.
- hi/lo change only on FIX writeback, MTHI/MTLO, or reset.

Decomposition:
- Op encodings go in a shared header MulDivop.vh, alongside ALUop.vh: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- State encodings are local parameters.
- One natural sub-module: md_sign_fix. It is combinational, WIDTH-parametrised, and handles conditional two's-complement negation of the product, quotient and remainder. The same block is reused for the operand-magnitude step.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at E33; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=0xFFFFFFF9 (-7) b=2 started in the done cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 -> hi/lo update at the accepting edge; busy and done never assert. A start pulse during a MULTU is ignored and the MULTU result is unaffected.
- MULTU 5*6 with abort at RUN cycle 10 -> busy drops next edge, no done, hi/lo keep prior values. A following MULTU 5*6 gives lo=30, hi=0.
- Assert rst asynchronously mid-DIV (between edges) -> busy, done, hi and lo go to 0 immediately. After release, DIVU 17/5 -> lo=3, hi=2.
